// File: rtl/cpu_types_pkg.sv
// Shared encodings for the multicycle MIPS core: ALU ops, opcodes, functs,
// and the control-unit state/select types.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, HALT
    } mcstate_t;

    typedef enum logic [1:0] {ASEL_RS, ASEL_RT, ASEL_IMM_ZE} asel_t;

    typedef enum logic [2:0] {
        BSEL_RT, BSEL_IMM_SE, BSEL_IMM_ZE, BSEL_SHAMT, BSEL_C16
    } bsel_t;

    typedef enum logic [1:0] {W_ALU_RD, W_ALU_RT, W_MEM_RT, W_PC4_R31} wsel_t;

    typedef enum logic [1:0] {PCSRC_PC4, PCSRC_BRANCH, PCSRC_JUMP, PCSRC_JR} pcsrc_t;

    // IC_ALU_OVF marks the signed ops (ADD, SUB, ADDI) that may trap on overflow.
    typedef enum logic [3:0] {
        IC_NOP, IC_ALU, IC_ALU_OVF, IC_LW, IC_SW, IC_BEQ, IC_BNE,
        IC_J, IC_JAL, IC_JR, IC_HALT
    } iclass_t;

endpackage

// File: rtl/mc_control_if.sv
// Control-unit bundle: instruction/data memory handshake, ALU control and
// flags, writeback and PC controls.
interface mc_control_if;
    import cpu_types_pkg::*;

    logic [31:0] instr;
    logic        ihit;
    logic        dhit;
    logic        z_fl;
    logic        o_fl;
    aluop_t      alu_op;
    asel_t       a_sel;
    bsel_t       b_sel;
    logic        iren;
    logic        ir_en;
    logic        dren;
    logic        dwen;
    logic        regwen;
    wsel_t       w_sel;
    logic        pc_en;
    pcsrc_t      pcsrc;
    logic        halt;
    logic        exc;

    modport master (
        input  instr, ihit, dhit, z_fl, o_fl,
        output alu_op, a_sel, b_sel, iren, ir_en, dren, dwen,
               regwen, w_sel, pc_en, pcsrc, halt, exc
    );

    modport slave (
        output instr, ihit, dhit, z_fl, o_fl,
        input  alu_op, a_sel, b_sel, iren, ir_en, dren, dwen,
               regwen, w_sel, pc_en, pcsrc, halt, exc
    );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: instruction class plus the ALU op,
// operand selects and writeback select used in EXEC/MEM/WB.
module mc_decode
    import cpu_types_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_t     iclass,
    output aluop_t      alu_op,
    output asel_t       a_sel,
    output bsel_t       b_sel,
    output wsel_t       w_sel
);

    opcode_t op;
    funct_t  fn;
    logic    unused_fields;

    assign op            = opcode_t'(instr[31:26]);
    assign fn            = funct_t'(instr[5:0]);
    assign unused_fields = ^instr[25:6];

    always_comb begin
        iclass = IC_NOP;
        alu_op = ALU_ADD;
        a_sel  = ASEL_RS;
        b_sel  = BSEL_RT;
        w_sel  = W_ALU_RD;
        case (op)
            OP_RTYPE: begin
                iclass = IC_ALU;
                case (fn)
                    FN_ADD:  iclass = IC_ALU_OVF;
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB:  begin iclass = IC_ALU_OVF; alu_op = ALU_SUB; end
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  begin alu_op = ALU_SLL; a_sel = ASEL_RT; b_sel = BSEL_SHAMT; end
                    FN_SRL:  begin alu_op = ALU_SRL; a_sel = ASEL_RT; b_sel = BSEL_SHAMT; end
                    FN_JR:   iclass = IC_JR;
                    default: iclass = IC_NOP;
                endcase
            end
            OP_ADDI:  begin iclass = IC_ALU_OVF; b_sel = BSEL_IMM_SE; w_sel = W_ALU_RT; end
            OP_ADDIU: begin iclass = IC_ALU; b_sel = BSEL_IMM_SE; w_sel = W_ALU_RT; end
            OP_SLTI:  begin iclass = IC_ALU; alu_op = ALU_SLT; b_sel = BSEL_IMM_SE; w_sel = W_ALU_RT; end
            OP_SLTIU: begin iclass = IC_ALU; alu_op = ALU_SLTU; b_sel = BSEL_IMM_SE; w_sel = W_ALU_RT; end
            OP_ANDI:  begin iclass = IC_ALU; alu_op = ALU_AND; b_sel = BSEL_IMM_ZE; w_sel = W_ALU_RT; end
            OP_ORI:   begin iclass = IC_ALU; alu_op = ALU_OR; b_sel = BSEL_IMM_ZE; w_sel = W_ALU_RT; end
            OP_XORI:  begin iclass = IC_ALU; alu_op = ALU_XOR; b_sel = BSEL_IMM_ZE; w_sel = W_ALU_RT; end
            // LUI shifts the zero-extended immediate left by the constant 16.
            OP_LUI:   begin iclass = IC_ALU; alu_op = ALU_SLL; a_sel = ASEL_IMM_ZE; b_sel = BSEL_C16; w_sel = W_ALU_RT; end
            OP_LW:    begin iclass = IC_LW; b_sel = BSEL_IMM_SE; w_sel = W_MEM_RT; end
            OP_SW:    begin iclass = IC_SW; b_sel = BSEL_IMM_SE; end
            OP_BEQ:   begin iclass = IC_BEQ; alu_op = ALU_SUB; end
            OP_BNE:   begin iclass = IC_BNE; alu_op = ALU_SUB; end
            OP_J:     iclass = IC_J;
            OP_JAL:   begin iclass = IC_JAL; w_sel = W_PC4_R31; end
            OP_HALT:  iclass = IC_HALT;
            default:  iclass = IC_NOP;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP/HALT).
// Define OVERFLOW_TRAP_EN to halt with exc=1 on signed overflow of ADD/SUB/ADDI.
module mc_control
    import cpu_types_pkg::*;
(
    input logic          CLK,
    input logic          nRST,
    mc_control_if.master bus
);

    mcstate_t state, next_state;
    logic     halt_q;
    logic     ovf_trap;
    iclass_t  iclass;
    aluop_t   dec_alu;
    asel_t    dec_a;
    bsel_t    dec_b;
    wsel_t    dec_w;

    mc_decode u_decode (
        .instr  (bus.instr),
        .iclass (iclass),
        .alu_op (dec_alu),
        .a_sel  (dec_a),
        .b_sel  (dec_b),
        .w_sel  (dec_w)
    );

`ifdef OVERFLOW_TRAP_EN
    logic exc_q;

    assign ovf_trap = (iclass == IC_ALU_OVF) && bus.o_fl;
    assign bus.exc  = exc_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                          exc_q <= 1'b0;
        else if (state == EXEC && ovf_trap) exc_q <= 1'b1;
    end
`else
    logic unused_o_fl;

    assign unused_o_fl = bus.o_fl;
    assign ovf_trap    = 1'b0;
    assign bus.exc     = 1'b0;
`endif

    assign bus.halt = halt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= FETCH;
            halt_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == HALT) halt_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        bus.iren   = 1'b0;
        bus.ir_en  = 1'b0;
        bus.dren   = 1'b0;
        bus.dwen   = 1'b0;
        bus.regwen = 1'b0;
        bus.pc_en  = 1'b0;
        bus.pcsrc  = PCSRC_PC4;
        bus.alu_op = ALU_ADD;
        bus.a_sel  = ASEL_RS;
        bus.b_sel  = BSEL_RT;
        bus.w_sel  = W_ALU_RD;
        case (state)
            FETCH: begin
                bus.iren = 1'b1;
                if (bus.ihit) begin
                    bus.ir_en  = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                case (iclass)
                    IC_ALU, IC_ALU_OVF, IC_LW, IC_SW: next_state = EXEC;
                    IC_BEQ, IC_BNE:                   next_state = BRANCH;
                    IC_J, IC_JAL, IC_JR:              next_state = JUMP;
                    IC_HALT:                          next_state = HALT;
                    default:                          next_state = WB;
                endcase
            end
            EXEC: begin
                bus.alu_op = dec_alu;
                bus.a_sel  = dec_a;
                bus.b_sel  = dec_b;
                if (ovf_trap)                                 next_state = HALT;
                else if (iclass == IC_LW || iclass == IC_SW)  next_state = MEM;
                else                                          next_state = WB;
            end
            // Keep the address computation driven while the memory request is held.
            MEM: begin
                bus.alu_op = dec_alu;
                bus.a_sel  = dec_a;
                bus.b_sel  = dec_b;
                if (iclass == IC_LW) begin
                    bus.dren = 1'b1;
                    if (bus.dhit) next_state = WB;
                end else begin
                    bus.dwen = 1'b1;
                    if (bus.dhit) begin
                        bus.pc_en  = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            WB: begin
                bus.alu_op = dec_alu;
                bus.a_sel  = dec_a;
                bus.b_sel  = dec_b;
                bus.w_sel  = dec_w;
                bus.regwen = (iclass != IC_NOP);
                bus.pc_en  = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                bus.alu_op = ALU_SUB;
                bus.pc_en  = 1'b1;
                if ((iclass == IC_BEQ && bus.z_fl) || (iclass == IC_BNE && !bus.z_fl))
                    bus.pcsrc = PCSRC_BRANCH;
                next_state = FETCH;
            end
            JUMP: begin
                bus.pc_en = 1'b1;
                bus.pcsrc = (iclass == IC_JR) ? PCSRC_JR : PCSRC_JUMP;
                if (iclass == IC_JAL) begin
                    bus.regwen = 1'b1;
                    bus.w_sel  = W_PC4_R31;
                end
                next_state = FETCH;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks instruction sequences cycle by cycle
// and compares the control outputs against hand-derived values.
module tb_mc_control;
    import cpu_types_pkg::*;

    localparam logic [31:0] I_ADDI  = 32'h20010005;
    localparam logic [31:0] I_ADDIU = 32'h24010005;
    localparam logic [31:0] I_LW    = 32'h8C220004;
    localparam logic [31:0] I_SW    = 32'hAC220008;
    localparam logic [31:0] I_BEQ   = 32'h10220003;
    localparam logic [31:0] I_BNE   = 32'h14220003;
    localparam logic [31:0] I_ADD   = 32'h00221820;
    localparam logic [31:0] I_ADDU  = 32'h00221821;
    localparam logic [31:0] I_SUBU  = 32'h00221823;
    localparam logic [31:0] I_LUI   = 32'h3C031234;
    localparam logic [31:0] I_SLL   = 32'h00021900;
    localparam logic [31:0] I_ANDI  = 32'h3022000F;
    localparam logic [31:0] I_SLTI  = 32'h28220005;
    localparam logic [31:0] I_J     = 32'h08000010;
    localparam logic [31:0] I_JAL   = 32'h0C000010;
    localparam logic [31:0] I_JR    = 32'h03E00008;
    localparam logic [31:0] I_BAD   = 32'hF8000000;
    localparam logic [31:0] I_HALT  = 32'hFC000000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   cyc_cnt;
    int   pc_cnt, ir_cnt, dren_cnt, dwen_cnt;
    int   base_cyc, base_pc, base_ir, base_dren, base_dwen;

    mc_control_if bus();

    mc_control dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        pc_cnt = 0; ir_cnt = 0; dren_cnt = 0; dwen_cnt = 0;
    end

    always @(negedge clk) begin
        if (bus.pc_en) pc_cnt   <= pc_cnt + 1;
        if (bus.ir_en) ir_cnt   <= ir_cnt + 1;
        if (bus.dren)  dren_cnt <= dren_cnt + 1;
        if (bus.dwen)  dwen_cnt <= dwen_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        cyc_cnt++;
    endtask

    task automatic fetch(input logic [31:0] ins, input int waits);
        bus.instr = ins;
        bus.ihit  = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            chk("fetch_wait_iren", 32'(bus.iren), 32'd1);
            chk("fetch_wait_ir_en", 32'(bus.ir_en), 32'd0);
            cyc();
        end
        bus.ihit = 1'b1;
        #1;
        chk("fetch_iren", 32'(bus.iren), 32'd1);
        chk("fetch_ir_en", 32'(bus.ir_en), 32'd1);
        chk("fetch_pc_en", 32'(bus.pc_en), 32'd0);
        cyc();
        bus.ihit = 1'b0;
    endtask

    task automatic decode();
        #1;
        chk("dec_iren", 32'(bus.iren), 32'd0);
        chk("dec_pc_en", 32'(bus.pc_en), 32'd0);
        chk("dec_alu_idle", 32'(bus.alu_op), 32'(ALU_ADD));
        cyc();
    endtask

    task automatic alu_instr(input string tag, input logic [31:0] ins, input int waits,
                             input logic ofl, input aluop_t alu, input asel_t a,
                             input bsel_t b, input wsel_t w);
        fetch(ins, waits);
        decode();
        bus.o_fl = ofl;
        #1;
        chk({tag, "_exec_alu"}, 32'(bus.alu_op), 32'(alu));
        chk({tag, "_exec_a"}, 32'(bus.a_sel), 32'(a));
        chk({tag, "_exec_b"}, 32'(bus.b_sel), 32'(b));
        chk({tag, "_exec_regwen"}, 32'(bus.regwen), 32'd0);
        cyc();
        bus.o_fl = 1'b0;
        #1;
        chk({tag, "_wb_regwen"}, 32'(bus.regwen), 32'd1);
        chk({tag, "_wb_pc_en"}, 32'(bus.pc_en), 32'd1);
        chk({tag, "_wb_pcsrc"}, 32'(bus.pcsrc), 32'(PCSRC_PC4));
        chk({tag, "_wb_w_sel"}, 32'(bus.w_sel), 32'(w));
        cyc();
    endtask

    task automatic branch_instr(input string tag, input logic [31:0] ins, input logic z,
                                input pcsrc_t exp_src);
        fetch(ins, 0);
        decode();
        bus.z_fl = z;
        #1;
        chk({tag, "_alu"}, 32'(bus.alu_op), 32'(ALU_SUB));
        chk({tag, "_pcsrc"}, 32'(bus.pcsrc), 32'(exp_src));
        chk({tag, "_pc_en"}, 32'(bus.pc_en), 32'd1);
        chk({tag, "_regwen"}, 32'(bus.regwen), 32'd0);
        cyc();
        bus.z_fl = 1'b0;
    endtask

    task automatic jump_instr(input string tag, input logic [31:0] ins, input pcsrc_t exp_src,
                              input logic exp_reg, input wsel_t exp_w);
        fetch(ins, 0);
        decode();
        #1;
        chk({tag, "_pcsrc"}, 32'(bus.pcsrc), 32'(exp_src));
        chk({tag, "_pc_en"}, 32'(bus.pc_en), 32'd1);
        chk({tag, "_regwen"}, 32'(bus.regwen), 32'(exp_reg));
        chk({tag, "_w_sel"}, 32'(bus.w_sel), 32'(exp_w));
        cyc();
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc_cnt = 0;
        rst_n = 1'b0;
        bus.instr = 32'h0; bus.ihit = 1'b0; bus.dhit = 1'b0;
        bus.z_fl = 1'b0; bus.o_fl = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_iren", 32'(bus.iren), 32'd1);
        chk("rst_halt", 32'(bus.halt), 32'd0);
        chk("rst_exc", 32'(bus.exc), 32'd0);
        chk("rst_ctrl", {26'd0, bus.ir_en, bus.dren, bus.dwen, bus.regwen, bus.pc_en, 1'b0}, 32'd0);
        chk("rst_alu", 32'(bus.alu_op), 32'(ALU_ADD));
        chk("rst_sels", {23'd0, bus.a_sel, bus.b_sel, bus.w_sel, bus.pcsrc},
            {23'd0, 2'(ASEL_RS), 3'(BSEL_RT), 2'(W_ALU_RD), 2'(PCSRC_PC4)});
        rst_n = 1'b1;
        cyc();

        // ADDI with two ihit wait cycles: six cycles, one ir_en, one pc_en.
        base_cyc = cyc_cnt; base_pc = pc_cnt; base_ir = ir_cnt;
        alu_instr("addi", I_ADDI, 2, 1'b0, ALU_ADD, ASEL_RS, BSEL_IMM_SE, W_ALU_RT);
        chk("addi_cycles", 32'(cyc_cnt - base_cyc), 32'd6);
        chk("addi_ir_en_pulses", 32'(ir_cnt - base_ir), 32'd1);
        chk("addi_pc_en_pulses", 32'(pc_cnt - base_pc), 32'd1);
        #1;
        chk("addi_back_fetch", 32'(bus.iren), 32'd1);

        // LW with dhit three cycles late.
        base_cyc = cyc_cnt; base_dren = dren_cnt; base_dwen = dwen_cnt;
        fetch(I_LW, 0);
        decode();
        #1;
        chk("lw_exec_alu", 32'(bus.alu_op), 32'(ALU_ADD));
        chk("lw_exec_b", 32'(bus.b_sel), 32'(BSEL_IMM_SE));
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_mem_dren", 32'(bus.dren), 32'd1);
            chk("lw_mem_pc_en", 32'(bus.pc_en), 32'd0);
            cyc();
        end
        bus.dhit = 1'b1;
        #1;
        chk("lw_mem_hit_dren", 32'(bus.dren), 32'd1);
        chk("lw_mem_hit_pc_en", 32'(bus.pc_en), 32'd0);
        cyc();
        bus.dhit = 1'b0;
        #1;
        chk("lw_wb_w_sel", 32'(bus.w_sel), 32'(W_MEM_RT));
        chk("lw_wb_regwen", 32'(bus.regwen), 32'd1);
        chk("lw_wb_pc_en", 32'(bus.pc_en), 32'd1);
        cyc();
        chk("lw_cycles", 32'(cyc_cnt - base_cyc), 32'd8);
        chk("lw_dren_cycles", 32'(dren_cnt - base_dren), 32'd4);
        chk("lw_no_dwen", 32'(dwen_cnt - base_dwen), 32'd0);

        // Branches: taken/not-taken for both polarities.
        base_pc = pc_cnt; base_cyc = cyc_cnt;
        branch_instr("beq_z1", I_BEQ, 1'b1, PCSRC_BRANCH);
        branch_instr("bne_z1", I_BNE, 1'b1, PCSRC_PC4);
        branch_instr("bne_z0", I_BNE, 1'b0, PCSRC_BRANCH);
        branch_instr("beq_z0", I_BEQ, 1'b0, PCSRC_PC4);
        chk("branch_pc_en_pulses", 32'(pc_cnt - base_pc), 32'd4);
        chk("branch_cycles", 32'(cyc_cnt - base_cyc), 32'd12);

        // Jumps.
        jump_instr("jal", I_JAL, PCSRC_JUMP, 1'b1, W_PC4_R31);
        jump_instr("j", I_J, PCSRC_JUMP, 1'b0, W_ALU_RD);
        jump_instr("jr", I_JR, PCSRC_JR, 1'b0, W_ALU_RD);

        // Operand-select variety.
        alu_instr("lui", I_LUI, 0, 1'b0, ALU_SLL, ASEL_IMM_ZE, BSEL_C16, W_ALU_RT);
        alu_instr("sll", I_SLL, 0, 1'b0, ALU_SLL, ASEL_RT, BSEL_SHAMT, W_ALU_RD);
        alu_instr("andi", I_ANDI, 0, 1'b0, ALU_AND, ASEL_RS, BSEL_IMM_ZE, W_ALU_RT);
        alu_instr("slti", I_SLTI, 1, 1'b0, ALU_SLT, ASEL_RS, BSEL_IMM_SE, W_ALU_RT);
        alu_instr("subu_ovf", I_SUBU, 0, 1'b1, ALU_SUB, ASEL_RS, BSEL_RT, W_ALU_RD);
        alu_instr("addu_ovf", I_ADDU, 0, 1'b1, ALU_ADD, ASEL_RS, BSEL_RT, W_ALU_RD);
        alu_instr("addiu_ovf", I_ADDIU, 0, 1'b1, ALU_ADD, ASEL_RS, BSEL_IMM_SE, W_ALU_RT);

        // Unsupported opcode retires as a NOP.
        fetch(I_BAD, 0);
        decode();
        #1;
        chk("nop_regwen", 32'(bus.regwen), 32'd0);
        chk("nop_pc_en", 32'(bus.pc_en), 32'd1);
        cyc();

        // ADD overflowing (0x7FFFFFFF + 1).
`ifdef OVERFLOW_TRAP_EN
        fetch(I_ADD, 0);
        decode();
        bus.o_fl = 1'b1;
        #1;
        chk("add_ovf_exec_regwen", 32'(bus.regwen), 32'd0);
        chk("add_ovf_exec_pc_en", 32'(bus.pc_en), 32'd0);
        cyc();
        bus.o_fl = 1'b0;
        #1;
        chk("add_ovf_halt", 32'(bus.halt), 32'd1);
        chk("add_ovf_exc", 32'(bus.exc), 32'd1);
        chk("add_ovf_regwen", 32'(bus.regwen), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("add_ovf_rst_exc", 32'(bus.exc), 32'd0);
        rst_n = 1'b1;
        cyc();
`else
        alu_instr("add_ovf", I_ADD, 0, 1'b1, ALU_ADD, ASEL_RS, BSEL_RT, W_ALU_RD);
        #1;
        chk("add_ovf_exc", 32'(bus.exc), 32'd0);
        chk("add_ovf_halt", 32'(bus.halt), 32'd0);
`endif

        // SW completing after one wait cycle.
        base_pc = pc_cnt; base_cyc = cyc_cnt;
        fetch(I_SW, 0);
        decode();
        #1;
        chk("sw_exec_b", 32'(bus.b_sel), 32'(BSEL_IMM_SE));
        cyc();
        #1;
        chk("sw_mem_dwen", 32'(bus.dwen), 32'd1);
        chk("sw_mem_dren", 32'(bus.dren), 32'd0);
        chk("sw_mem_pc_en", 32'(bus.pc_en), 32'd0);
        cyc();
        bus.dhit = 1'b1;
        #1;
        chk("sw_hit_pc_en", 32'(bus.pc_en), 32'd1);
        chk("sw_hit_pcsrc", 32'(bus.pcsrc), 32'(PCSRC_PC4));
        chk("sw_hit_regwen", 32'(bus.regwen), 32'd0);
        cyc();
        bus.dhit = 1'b0;
        chk("sw_cycles", 32'(cyc_cnt - base_cyc), 32'd5);
        chk("sw_pc_en_pulses", 32'(pc_cnt - base_pc), 32'd1);

        // SW interrupted by reset while waiting for dhit.
        base_pc = pc_cnt;
        fetch(I_SW, 0);
        decode();
        cyc();
        #1;
        chk("swrst_dwen_before", 32'(bus.dwen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("swrst_dwen_drop", 32'(bus.dwen), 32'd0);
        chk("swrst_iren", 32'(bus.iren), 32'd1);
        chk("swrst_regwen", 32'(bus.regwen), 32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("swrst_fetch_iren", 32'(bus.iren), 32'd1);
        chk("swrst_no_pc_en", 32'(pc_cnt - base_pc), 32'd0);
        cyc();

        // HALT: sticky for 100 cycles, ihit ignored.
        fetch(I_HALT, 0);
        decode();
        base_ir = ir_cnt; base_pc = pc_cnt;
        for (int i = 0; i < 100; i++) begin
            bus.ihit = i[0];
            #1;
            chk("halt_flag", 32'(bus.halt), 32'd1);
            chk("halt_ir_en", 32'(bus.ir_en), 32'd0);
            chk("halt_iren", 32'(bus.iren), 32'd0);
            cyc();
        end
        bus.ihit = 1'b0;
        chk("halt_no_ir_en", 32'(ir_cnt - base_ir), 32'd0);
        chk("halt_no_pc_en", 32'(pc_cnt - base_pc), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_clear", 32'(bus.halt), 32'd0);
        chk("halt_rst_iren", 32'(bus.iren), 32'd1);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
